// File: rtl/pacman_move_ctrl.sv
// Pacman movement controller: one grid step per movement tick,
// with buffered turns resolved against an external synchronous wall map.
module pacman_move_ctrl #(
   parameter int GRID_W   = 16,
   parameter int GRID_H   = 16,
   parameter int START_X  = 1,
   parameter int START_Y  = 1,
   parameter int STEP_DIV = 2000000,
   localparam int XW = $clog2(GRID_W),
   localparam int YW = $clog2(GRID_H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    dir,
   input  logic          wall_rdata,
   output logic          wall_req,
   output logic [XW-1:0] wall_x,
   output logic [YW-1:0] wall_y,
   output logic [XW-1:0] pos_x,
   output logic [YW-1:0] pos_y,
   output logic [3:0]    cur_dir,
   output logic          moved,
   output logic          blocked,
   output logic          busy
);

   localparam int CW = $clog2(STEP_DIV);
   localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
   localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);

   typedef enum logic [2:0] {
      IDLE,
      Q_DES,
      W_DES,
      Q_CUR,
      W_CUR
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic          tick;
   logic [3:0]    des_dir;
   logic          data_ph;
   logic [XW-1:0] dx, cx;
   logic [YW-1:0] dy, cy;

   // Neighbouring cell in direction d, wrapping at every edge.
   function automatic logic [XW+YW-1:0] step(
      input logic [3:0]    d,
      input logic [XW-1:0] x,
      input logic [YW-1:0] y
   );
      logic [XW-1:0] nx;
      logic [YW-1:0] ny;
      nx = x;
      ny = y;
      case (d)
         4'b0001: nx = (x == XMAX) ? '0 : x + 1'b1;
         4'b0100: nx = (x == '0) ? XMAX : x - 1'b1;
         4'b0010: ny = (y == YMAX) ? '0 : y + 1'b1;
         4'b1000: ny = (y == '0) ? YMAX : y - 1'b1;
         default: ;
      endcase
      return {nx, ny};
   endfunction

   assign {dx, dy} = step(des_dir, pos_x, pos_y);
   assign {cx, cy} = step(cur_dir, pos_x, pos_y);
   assign tick     = (count == CW'(STEP_DIV - 1));
   assign busy     = (state != IDLE);

   // Free-running movement tick divider.
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (tick)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   // Move FSM; each W state spans the request cycle and the data cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         pos_x    <= XW'(START_X);
         pos_y    <= YW'(START_Y);
         cur_dir  <= '0;
         des_dir  <= '0;
         wall_req <= 1'b0;
         wall_x   <= '0;
         wall_y   <= '0;
         moved    <= 1'b0;
         blocked  <= 1'b0;
         data_ph  <= 1'b0;
      end else begin
         wall_req <= 1'b0;
         moved    <= 1'b0;
         blocked  <= 1'b0;
         case (state)
            IDLE: begin
               if (tick) begin
                  des_dir <= dir;
                  state   <= Q_DES;
               end
            end
            Q_DES: begin
               data_ph <= 1'b0;
               if ($onehot(des_dir)) begin
                  wall_x   <= dx;
                  wall_y   <= dy;
                  wall_req <= 1'b1;
                  state    <= W_DES;
               end else begin
                  state <= Q_CUR;
               end
            end
            W_DES: begin
               if (!data_ph) begin
                  data_ph <= 1'b1;
               end else if (!wall_rdata) begin
                  pos_x   <= wall_x;
                  pos_y   <= wall_y;
                  cur_dir <= des_dir;
                  moved   <= 1'b1;
                  state   <= IDLE;
               end else begin
                  state <= Q_CUR;
               end
            end
            Q_CUR: begin
               data_ph <= 1'b0;
               if (cur_dir == 4'b0000) begin
                  blocked <= 1'b1;
                  state   <= IDLE;
               end else begin
                  wall_x   <= cx;
                  wall_y   <= cy;
                  wall_req <= 1'b1;
                  state    <= W_CUR;
               end
            end
            W_CUR: begin
               if (!data_ph) begin
                  data_ph <= 1'b1;
               end else begin
                  if (!wall_rdata) begin
                     pos_x <= wall_x;
                     pos_y <= wall_y;
                     moved <= 1'b1;
                  end else begin
                     cur_dir <= '0;
                     blocked <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Self-checking bench for pacman_move_ctrl with a 1-cycle wall map
// and a cell-level reference model of Pacman's movement rules.
module tb_pacman_move_ctrl;

   localparam int SD = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] dir = 4'b0000;
   logic       wall_rdata = 1'b0;
   logic       wall_req;
   logic [3:0] wall_x, wall_y;
   logic [3:0] pos_x, pos_y;
   logic [3:0] cur_dir;
   logic       moved, blocked, busy;

   int tests = 0;
   int fails = 0;

   bit wmap [16][16];
   int qx[$];
   int qy[$];

   int         mx, my;
   logic [3:0] mcur;
   bit         exp_mv;
   int         exp_nq;

   pacman_move_ctrl #(
      .GRID_W(16), .GRID_H(16), .START_X(1), .START_Y(1), .STEP_DIV(SD)
   ) dut (
      .clk(clk), .reset(reset), .dir(dir), .wall_rdata(wall_rdata),
      .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
      .pos_x(pos_x), .pos_y(pos_y), .cur_dir(cur_dir),
      .moved(moved), .blocked(blocked), .busy(busy)
   );

   // 100 MHz-style clock.
   always #5 clk = ~clk;

   // Synchronous wall map: data valid the cycle after the request.
   always @(posedge clk)
      wall_rdata <= wall_req ? wmap[wall_x][wall_y] : 1'b0;

   // Log every lookup address.
   always @(negedge clk)
      if (wall_req) begin
         qx.push_back(int'(wall_x));
         qy.push_back(int'(wall_y));
      end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic clear_map();
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            wmap[x][y] = 1'b0;
   endtask

   task automatic nb(input logic [3:0] d, input int x, input int y,
                     output int tx, output int ty);
      tx = x;
      ty = y;
      case (d)
         4'b0001: tx = (x + 1) % 16;
         4'b0100: tx = (x + 15) % 16;
         4'b0010: ty = (y + 1) % 16;
         4'b1000: ty = (y + 15) % 16;
         default: ;
      endcase
   endtask

   // Game rule for one tick: try the requested turn, else keep going, else stop.
   task automatic model_tick(input logic [3:0] d);
      int tx, ty;
      exp_nq = 0;
      exp_mv = 0;
      if ($countones(d) == 1) begin
         nb(d, mx, my, tx, ty);
         exp_nq++;
         if (!wmap[tx][ty]) begin
            mx = tx;
            my = ty;
            mcur = d;
            exp_mv = 1;
            return;
         end
      end
      if (mcur == 4'b0000) return;
      nb(mcur, mx, my, tx, ty);
      exp_nq++;
      if (!wmap[tx][ty]) begin
         mx = tx;
         my = ty;
         exp_mv = 1;
      end else begin
         mcur = 4'b0000;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
      mx = 1;
      my = 1;
      mcur = 4'b0000;
      qx.delete();
      qy.delete();
   endtask

   // Wait for the pulse that ends a tick; reports timeout and pulse kinds.
   task automatic run_tick(output bit tmo, output bit mv, output bit bl);
      tmo = 1;
      mv = 0;
      bl = 0;
      for (int i = 0; i < 4 * SD; i++) begin
         @(negedge clk);
         if (moved || blocked) begin
            mv = moved;
            bl = blocked;
            tmo = 0;
            break;
         end
      end
   endtask

   // Negedges from the current one until wall_req is seen.
   task automatic wait_req(output int n);
      n = 0;
      for (int i = 0; i < 4 * SD; i++) begin
         @(negedge clk);
         n++;
         if (wall_req) break;
      end
      if (!wall_req) n = -1;
   endtask

   task automatic test_reset();
      int n;
      clear_map();
      dir = 4'b0001;
      do_reset(3);
      tests++;
      if (pos_x !== 4'd1 || pos_y !== 4'd1) begin
         fails++;
         $display("FAIL reset_pos: got (%0d,%0d) want (1,1)", pos_x, pos_y);
      end
      tests++;
      if (cur_dir !== 4'b0000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: cur_dir=%b busy=%b want 0000/0", cur_dir, busy);
      end
      tests++;
      if (wall_req !== 1'b0 || moved !== 1'b0 || blocked !== 1'b0) begin
         fails++;
         $display("FAIL reset_pulses: req=%b mv=%b bl=%b want 0", wall_req, moved, blocked);
      end
      wait_req(n);
      // SD edges reach the tick edge; the request registers one edge later.
      tests++;
      if (n != SD + 1) begin
         fails++;
         $display("FAIL first_req_time: got %0d edges want %0d", n, SD + 1);
      end
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL busy_in_query: got %b want 1", busy);
      end
   endtask

   task automatic test_free_move();
      bit tmo, mv, bl;
      int n;
      clear_map();
      dir = 4'b0001;
      do_reset(2);
      model_tick(dir);
      wait_req(n);
      tests++;
      if (wall_x !== 4'd2 || wall_y !== 4'd1) begin
         fails++;
         $display("FAIL free_query: got (%0d,%0d) want (2,1)", wall_x, wall_y);
      end
      run_tick(tmo, mv, bl);
      tests++;
      if (tmo || !mv || bl) begin
         fails++;
         $display("FAIL free_pulse: tmo=%0d mv=%0d bl=%0d want 0/1/0", tmo, mv, bl);
      end
      tests++;
      if (pos_x !== 4'(mx) || pos_y !== 4'(my) || cur_dir !== mcur) begin
         fails++;
         $display("FAIL free_pos: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                  pos_x, pos_y, cur_dir, mx, my, mcur);
      end
      model_tick(dir);
      n = 0;
      for (int i = 0; i < 4 * SD; i++) begin
         @(negedge clk);
         if (wall_req) n = 1;
         else if (n > 0) n++;
         if (moved) break;
      end
      // Request cycle then data cycle: moved appears two edges after wall_req.
      tests++;
      if (n != 3 || pos_x !== 4'(mx) || pos_y !== 4'(my)) begin
         fails++;
         $display("FAIL free_second: pos=(%0d,%0d) lat=%0d want (%0d,%0d) lat=3",
                  pos_x, pos_y, n, mx, my);
      end
   endtask

   task automatic test_buffered_turn();
      bit tmo, mv, bl;
      wmap[3][0] = 1'b1;
      dir = 4'b1000;
      qx.delete();
      qy.delete();
      model_tick(dir);
      run_tick(tmo, mv, bl);
      tests++;
      if (qx.size() != 2) begin
         fails++;
         $display("FAIL turn_nq: got %0d queries want 2", qx.size());
      end else if (qx[0] != 3 || qy[0] != 0 || qx[1] != 4 || qy[1] != 1) begin
         fails++;
         $display("FAIL turn_query: got (%0d,%0d),(%0d,%0d) want (3,0),(4,1)",
                  qx[0], qy[0], qx[1], qy[1]);
      end
      tests++;
      if (tmo || !mv || pos_x !== 4'(mx) || pos_y !== 4'(my) || cur_dir !== mcur) begin
         fails++;
         $display("FAIL turn_fallback: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                  pos_x, pos_y, cur_dir, mx, my, mcur);
      end
      model_tick(dir);
      run_tick(tmo, mv, bl);
      tests++;
      if (tmo || !mv || pos_x !== 4'd4 || pos_y !== 4'd0 || cur_dir !== 4'b1000) begin
         fails++;
         $display("FAIL turn_taken: got (%0d,%0d,%b) want (4,0,1000)",
                  pos_x, pos_y, cur_dir);
      end
   endtask

   task automatic test_dead_end();
      bit tmo, mv, bl;
      dir = 4'b0001;
      model_tick(dir);
      run_tick(tmo, mv, bl);
      wmap[6][0] = 1'b1;
      qx.delete();
      qy.delete();
      model_tick(dir);
      run_tick(tmo, mv, bl);
      tests++;
      if (tmo || mv || !bl || cur_dir !== 4'b0000 || pos_x !== 4'd5 || pos_y !== 4'd0) begin
         fails++;
         $display("FAIL dead_end: mv=%0d bl=%0d got (%0d,%0d,%b) want bl (5,0,0000)",
                  mv, bl, pos_x, pos_y, cur_dir);
      end
      tests++;
      if (qx.size() != exp_nq) begin
         fails++;
         $display("FAIL dead_end_nq: got %0d queries want %0d", qx.size(), exp_nq);
      end
      dir = 4'b0011;
      qx.delete();
      qy.delete();
      model_tick(dir);
      run_tick(tmo, mv, bl);
      tests++;
      if (tmo || mv || !bl || qx.size() != 0) begin
         fails++;
         $display("FAIL multi_hot: mv=%0d bl=%0d nq=%0d want 0/1/0", mv, bl, qx.size());
      end
   endtask

   task automatic test_wrap();
      bit tmo, mv, bl;
      clear_map();
      dir = 4'b0010;
      do_reset(1);
      for (int i = 0; i < 4; i++) begin
         model_tick(dir);
         run_tick(tmo, mv, bl);
      end
      dir = 4'b0100;
      for (int i = 0; i < 2; i++) begin
         model_tick(dir);
         run_tick(tmo, mv, bl);
      end
      tests++;
      if (pos_x !== 4'd15 || pos_y !== 4'd5 || pos_x !== 4'(mx)) begin
         fails++;
         $display("FAIL wrap_left: got (%0d,%0d) want (15,5)", pos_x, pos_y);
      end
      dir = 4'b0001;
      model_tick(dir);
      run_tick(tmo, mv, bl);
      tests++;
      if (tmo || !mv || pos_x !== 4'd0 || pos_y !== 4'd5) begin
         fails++;
         $display("FAIL wrap_right: got (%0d,%0d) want (0,5)", pos_x, pos_y);
      end
      do_reset(1);
      for (int i = 0; i < 2; i++) begin
         model_tick(dir);
         run_tick(tmo, mv, bl);
      end
      dir = 4'b1000;
      for (int i = 0; i < 2; i++) begin
         model_tick(dir);
         run_tick(tmo, mv, bl);
      end
      tests++;
      if (tmo || !mv || pos_x !== 4'd3 || pos_y !== 4'd15 || pos_y !== 4'(my)) begin
         fails++;
         $display("FAIL wrap_up: got (%0d,%0d) want (3,15)", pos_x, pos_y);
      end
   endtask

   task automatic test_random();
      bit tmo, mv, bl;
      logic [3:0] dtab [12];
      dtab = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
               4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1111, 4'b1010};
      do_reset(1);
      for (int t = 0; t < 80; t++) begin
         if (t % 8 == 0)
            for (int x = 0; x < 16; x++)
               for (int y = 0; y < 16; y++)
                  wmap[x][y] = ($urandom_range(0, 3) == 0);
         dir = dtab[$urandom_range(0, 11)];
         qx.delete();
         qy.delete();
         model_tick(dir);
         run_tick(tmo, mv, bl);
         tests++;
         if (tmo || mv != exp_mv || bl == exp_mv || qx.size() != exp_nq ||
             pos_x !== 4'(mx) || pos_y !== 4'(my) || cur_dir !== mcur) begin
            fails++;
            $display("FAIL random_%0d: dir=%b tmo=%0d mv=%0d bl=%0d nq=%0d pos=(%0d,%0d,%b) want mv=%0d nq=%0d (%0d,%0d,%b)",
                     t, dir, tmo, mv, bl, qx.size(), pos_x, pos_y, cur_dir,
                     exp_mv, exp_nq, mx, my, mcur);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      clear_map();
      dir = 4'b0001;
      do_reset(1);
      wait_req(n);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if (pos_x !== 4'd1 || pos_y !== 4'd1 || cur_dir !== 4'b0000 ||
          wall_req !== 1'b0 || busy !== 1'b0 || moved !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: pos=(%0d,%0d) cur=%b req=%b busy=%b mv=%b want (1,1) 0000 0 0 0",
                  pos_x, pos_y, cur_dir, wall_req, busy, moved);
      end
      reset = 1'b0;
      mx = 1;
      my = 1;
      mcur = 4'b0000;
      wait_req(n);
      tests++;
      if (n != SD + 1) begin
         fails++;
         $display("FAIL reset_mid_tick: got %0d edges want %0d", n, SD + 1);
      end
   endtask

   initial begin
      test_reset();
      test_free_move();
      test_buffered_turn();
      test_dead_end();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
